// File: rtl/dmux_pkg.sv
// dmux_pkg
// Shared constants for the gate-level steering primitives.
//   SEL_A : select value that routes the data input to output a
//   SEL_B : select value that routes the data input to output b
package dmux_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : dmux_pkg

// File: rtl/dmux_out_reg.sv
// dmux_out_reg
// Two-output register stage used by dmux when REGISTERED=1.
// Ports:
//   clk   : register clock
//   rst_n : asynchronous active-low clear of both outputs
//   i_a   : next value for output a (WIDTH bits)
//   i_b   : next value for output b (WIDTH bits)
//   o_a   : registered a (WIDTH bits)
//   o_b   : registered b (WIDTH bits)
module dmux_out_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    // Reset clears immediately and holds the outputs at zero, so any value
    // that was about to be captured when reset hit is simply lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= i_a;
            r_b <= i_b;
        end
    end

    assign o_a = r_a;
    assign o_b = r_b;

endmodule : dmux_out_reg

// File: rtl/dmux.sv
// dmux
// 1-to-2 demultiplexer: steers `in` to `a` when sel=SEL_A, to `b` when
// sel=SEL_B; the unselected output is driven 0, so a & b is always 0.
// Parameters:
//   WIDTH      : data width of in, a, b
//   REGISTERED : 0 = combinational outputs, 1 = outputs registered on clk
// Ports (declaration order keeps positional a, b, in, sel hookup legal):
//   a     : in when sel=0, else 0
//   b     : in when sel=1, else 0
//   in    : data to steer
//   sel   : select, 0 -> a, 1 -> b
//   clk   : clock, only used when REGISTERED=1
//   rst_n : async active-low reset, only used when REGISTERED=1
module dmux
    import dmux_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b0
) (
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    input  logic             clk,
    input  logic             rst_n
);

    logic             w_selN;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Core is kept as explicit not/and gates so it maps one-to-one onto
    // the gate library; an X on sel propagates to both outputs unmasked.
    not u_selInv (w_selN, sel);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        and u_andA (w_a[gi], in[gi], w_selN);
        and u_andB (w_b[gi], in[gi], sel);
    end

    if (REGISTERED) begin : g_reg
        dmux_out_reg #(
            .WIDTH (WIDTH)
        ) u_outReg (
            .clk   (clk),
            .rst_n (rst_n),
            .i_a   (w_a),
            .i_b   (w_b),
            .o_a   (a),
            .o_b   (b)
        );
    end else begin : g_comb
        // clk/rst_n have no function in the combinational build; they are
        // folded into a sink so the ports stay part of the interface.
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst_n};

        assign a = w_a;
        assign b = w_b;
    end

endmodule : dmux

// File: tb/tb_dmux.sv
// tb_dmux
// Self-checking bench for dmux: combinational truth table (named and
// positional hookup), random exclusivity, WIDTH=8 steering, and the
// registered variant's latency and asynchronous reset behaviour.
module tb_dmux;
    import dmux_pkg::*;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } expT;

    expT expQ[$];
    int  total = 0;
    int  bad   = 0;

    logic       clk = 1'b0;
    logic       rstN;

    logic       c1In, c1Sel, c1A, c1B;
    logic       pA, pB;
    logic [7:0] c8In, c8A, c8B;
    logic       c8Sel;
    logic       rIn, rSel, rA, rB;

    // Free-running clock for the registered instance
    always #5 clk = ~clk;

    dmux #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
        .a(c1A), .b(c1B), .in(c1In), .sel(c1Sel), .clk(clk), .rst_n(rstN)
    );

    // Positional hookup relies on the a, b, in, sel, clk, rst_n order
    dmux #(.WIDTH(1), .REGISTERED(1'b0)) u_pos (pA, pB, c1In, c1Sel, clk, rstN);

    dmux #(.WIDTH(8), .REGISTERED(1'b0)) u_c8 (
        .a(c8A), .b(c8B), .in(c8In), .sel(c8Sel), .clk(clk), .rst_n(rstN)
    );

    dmux #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
        .a(rA), .b(rB), .in(rIn), .sel(rSel), .clk(clk), .rst_n(rstN)
    );

    // Reference behaviour: selected output carries the data, the other is 0
    function automatic expT model(input logic [7:0] inV, input logic selV);
        expT e;
        if (selV == SEL_A) begin
            e.a = inV;
            e.b = 8'h00;
        end else begin
            e.a = 8'h00;
            e.b = inV;
        end
        return e;
    endfunction

    task automatic pushExpect(input logic [7:0] ea, input logic [7:0] eb);
        expT e;
        e.a = ea;
        e.b = eb;
        expQ.push_back(e);
    endtask

    // which: 1 = WIDTH=1 comb pair, 8 = WIDTH=8 comb; pushes model result
    task automatic applyStimulus(input int which, input logic [7:0] inV, input logic selV);
        if (which == 1) begin
            c1In  = inV[0];
            c1Sel = selV;
            expQ.push_back(model({7'b0, inV[0]}, selV));
        end else begin
            c8In  = inV;
            c8Sel = selV;
            expQ.push_back(model(inV, selV));
        end
        #10;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] actA, input logic [7:0] actB);
        expT e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("FAIL %s no expected entry queued, got a=%h b=%h", tag, actA, actB);
        end else begin
            e = expQ.pop_front();
            assert (actA === e.a && actB === e.b) else begin
                bad++;
                $error("FAIL %s got a=%h b=%h expected a=%h b=%h", tag, actA, actB, e.a, e.b);
            end
        end
    endtask

    initial begin
        logic [7:0] rv;
        logic       rs;
        rstN  = 1'b0;
        c1In  = 1'b0; c1Sel = 1'b0;
        c8In  = 8'h00; c8Sel = 1'b0;
        rIn   = 1'b0; rSel  = 1'b0;
        $display("[TB] start");

        // Truth table, named and positional instances share the inputs
        for (int i = 0; i < 4; i++) begin
            logic [1:0] combo;
            combo = 2'(i);
            applyStimulus(1, {7'b0, combo[0]}, combo[1]);
            expQ.push_back(model({7'b0, combo[0]}, combo[1]));
            checkOutput("tt_named", {7'b0, c1A}, {7'b0, c1B});
            checkOutput("tt_positional", {7'b0, pA}, {7'b0, pB});
        end

        // WIDTH=8 steering
        applyStimulus(8, 8'hA5, SEL_A);
        checkOutput("w8_selA", c8A, c8B);
        applyStimulus(8, 8'hA5, SEL_B);
        checkOutput("w8_selB", c8A, c8B);

        // Random exclusivity and coverage of in by a|b
        for (int i = 0; i < 1000; i++) begin
            rv = 8'($urandom);
            rs = 1'($urandom);
            c8In = rv; c8Sel = rs;
            c1In = rv[0]; c1Sel = rs;
            #1;
            total++;
            assert ((c8A & c8B) === 8'h00 && (c8A | c8B) === c8In) else begin
                bad++;
                $error("FAIL rand_w8 in=%h sel=%b got a=%h b=%h", c8In, c8Sel, c8A, c8B);
            end
            total++;
            assert ((c1A & c1B) === 1'b0 && (c1A | c1B) === c1In) else begin
                bad++;
                $error("FAIL rand_w1 in=%b sel=%b got a=%b b=%b", c1In, c1Sel, c1A, c1B);
            end
        end

        // Registered variant: reset state and hold while reset is low
        @(negedge clk);
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_reset", {7'b0, rA}, {7'b0, rB});
        rIn = 1'b1; rSel = SEL_A;
        @(posedge clk); #1;
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_hold_in_reset", {7'b0, rA}, {7'b0, rB});
        @(negedge clk);
        rstN = 1'b1;
        #1;
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_release_no_edge", {7'b0, rA}, {7'b0, rB});
        @(posedge clk); #1;
        pushExpect(8'h1, 8'h0);
        checkOutput("reg_first_load", {7'b0, rA}, {7'b0, rB});

        // One-cycle latency
        @(negedge clk);
        rIn = 1'b1; rSel = SEL_B;
        #1;
        pushExpect(8'h1, 8'h0);
        checkOutput("reg_before_edge", {7'b0, rA}, {7'b0, rB});
        @(posedge clk); #1;
        pushExpect(8'h0, 8'h1);
        checkOutput("reg_after_edge", {7'b0, rA}, {7'b0, rB});

        // Asynchronous clear between edges, hold until first edge after release
        #2;
        rstN = 1'b0;
        #1;
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_async_clear", {7'b0, rA}, {7'b0, rB});
        @(posedge clk); #1;
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_hold_low", {7'b0, rA}, {7'b0, rB});
        @(negedge clk);
        rstN = 1'b1;
        #1;
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_hold_until_edge", {7'b0, rA}, {7'b0, rB});
        @(posedge clk); #1;
        pushExpect(8'h0, 8'h1);
        checkOutput("reg_reload", {7'b0, rA}, {7'b0, rB});

        // Reset mid-stream discards the value set up for the next edge
        @(negedge clk);
        rIn = 1'b1; rSel = SEL_A;
        #2;
        rstN = 1'b0;
        #1;
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_midstream_clear", {7'b0, rA}, {7'b0, rB});
        @(negedge clk);
        rIn = 1'b0; rSel = SEL_A;
        rstN = 1'b1;
        @(posedge clk); #1;
        pushExpect(8'h0, 8'h0);
        checkOutput("reg_discard", {7'b0, rA}, {7'b0, rB});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmux
